// File: rtl/alu_share_arbiter.sv
// Round-robin share of one external combinational ALU between two requesters; ALU_ARB_ILLEGAL_OP_CHK_EN adds illegal-opcode decode.
// Latency: request accepted in cycle N, registered response valid in cycle N+1.
// Backpressure: a full, undrained response slot holds off only its own requester.
module alu_share_arbiter #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic             rsp0_zero,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic             rsp1_zero,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic             rsp1_err,
  output logic [31:0]      alu_operand_a,
  output logic [31:0]      alu_operand_b,
  output logic [3:0]       alu_control,
  input  logic [31:0]      alu_result,
  input  logic             alu_zero
);

  typedef struct packed {
    logic [31:0]      result;
    logic             zero;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  rsp_t             slot0_q, slot1_q, cap_d;
  logic             vld0_q, vld1_q;
  logic             last_grant_q;
  logic             elig0, elig1, grant0, grant1;
  logic [31:0]      sel_a, sel_b;
  logic [3:0]       sel_op;
  logic [TAG_W-1:0] sel_tag;

  // last_grant_q == 1 means requester 0 wins the next contention
  always_comb begin
    elig0  = req0_valid && (!vld0_q || rsp0_ready);
    elig1  = req1_valid && (!vld1_q || rsp1_ready);
    grant0 = elig0 && (!elig1 || last_grant_q);
    grant1 = elig1 && !grant0;
  end

  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_op  = '0;
    sel_tag = '0;
    if (grant0) begin
      sel_a   = req0_a;
      sel_b   = req0_b;
      sel_op  = req0_op;
      sel_tag = req0_tag;
    end else if (grant1) begin
      sel_a   = req1_a;
      sel_b   = req1_b;
      sel_op  = req1_op;
      sel_tag = req1_tag;
    end
  end

`ifdef ALU_ARB_ILLEGAL_OP_CHK_EN
  logic illegal;

  // Illegal opcodes park the ALU as idle and return a flagged zero result
  always_comb begin
    illegal       = (grant0 || grant1) && (sel_op > 4'h9);
    alu_operand_a = illegal ? 32'd0 : sel_a;
    alu_operand_b = illegal ? 32'd0 : sel_b;
    alu_control   = illegal ? 4'h0 : sel_op;
    cap_d.result  = illegal ? 32'd0 : alu_result;
    cap_d.zero    = illegal ? 1'b1 : alu_zero;
    cap_d.tag     = sel_tag;
    cap_d.err     = illegal;
  end
`else
  always_comb begin
    alu_operand_a = sel_a;
    alu_operand_b = sel_b;
    alu_control   = sel_op;
    cap_d.result  = alu_result;
    cap_d.zero    = alu_zero;
    cap_d.tag     = sel_tag;
    cap_d.err     = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      vld0_q       <= 1'b0;
      vld1_q       <= 1'b0;
      slot0_q      <= '0;
      slot1_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      // A grant on a draining slot reloads it without a bubble
      vld0_q <= grant0 || (vld0_q && !rsp0_ready);
      vld1_q <= grant1 || (vld1_q && !rsp1_ready);
      if (grant0) slot0_q <= cap_d;
      if (grant1) slot1_q <= cap_d;
      if (grant0)      last_grant_q <= 1'b0;
      else if (grant1) last_grant_q <= 1'b1;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign rsp0_valid  = vld0_q;
  assign rsp0_result = slot0_q.result;
  assign rsp0_zero   = slot0_q.zero;
  assign rsp0_tag    = slot0_q.tag;
  assign rsp0_err    = slot0_q.err;
  assign rsp1_valid  = vld1_q;
  assign rsp1_result = slot1_q.result;
  assign rsp1_zero   = slot1_q.zero;
  assign rsp1_tag    = slot1_q.tag;
  assign rsp1_err    = slot1_q.err;

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Two-requester arbiter that time-shares one combinational FastALU instance between the integer execute pipe (requester 0) and the address/branch unit (requester 1). Each cycle it grants at most one valid request using round-robin priority, steers that request's operands and opcode onto the ALU, and registers the ALU result into a per-requester response slot held under a valid/ready handshake. The ALU sits outside this block; the arbiter drives its inputs and samples its outputs in the same cycle.

## Interface
- TAG_W, 4, width of the requester-supplied transaction tag, returned unchanged with the response
- clk  input  1  single clock, rising-edge
- rst  input  1  synchronous, active-high reset
- req0_valid / req1_valid  input  1  request present
- req0_ready / req1_ready  output  1  request accepted this cycle (transfer = valid && ready)
- req0_a, req0_b / req1_a, req1_b  input  32  operands
- req0_op / req1_op  input  4  ALU opcode (0x0 OR, 0x1 XOR, 0x2 ADD, 0x3 SRL, 0x4 SLL, 0x5 SRA, 0x6 SUB, 0x7 SLT, 0x8 SLTU, 0x9 AND)
- req0_tag / req1_tag  input  TAG_W  transaction tag
- rsp0_valid / rsp1_valid  output  1  response slot full
- rsp0_ready / rsp1_ready  input  1  consumer drains slot (transfer = valid && ready)
- rsp0_result / rsp1_result  output  32  registered ALU result
- rsp0_zero / rsp1_zero  output  1  registered ALU zero flag
- rsp0_tag / rsp1_tag  output  TAG_W  tag of the request that produced the response
- rsp0_err / rsp1_err  output  1  illegal-opcode flag (see Configuration)
- alu_operand_a, alu_operand_b  output  32  to ALU
- alu_control  output  4  to ALU
- alu_result  input  32  from ALU
- alu_zero  input  1  from ALU

## Operation
- Eligibility: requester N eligible when reqN_valid && (!rspN_valid || rspN_ready); a full, undrained slot back-pressures its requester.
- Arbitration: one 1-bit last_grant register. Both eligible -> grant the requester != last_grant. One eligible -> grant it. None -> no grant. last_grant updates only on a grant.
- reqN_ready = grantN (combinational, depends on reqN_valid; requesters must not make valid depend on ready).
- Requesters hold a, b, op, tag stable while valid && !ready.
- ALU steering: grant0 -> req0 fields; grant1 -> req1 fields; no grant -> operands 0, alu_control 0x0.
- Capture: on grantN, rspN_result/zero/tag/err load at the clock edge and rspN_valid sets.
- Drain: rspN_valid && rspN_ready with no new grantN clears rspN_valid; data fields hold their last value.
- Simultaneous drain and grant on the same requester: slot reloads, rspN_valid stays 1 (no bubble).
- Requesters are independent: requester 1 never stalls because requester 0's slot is full.

## Timing
- Reset values: last_grant = 1 (requester 0 wins the first contention), rsp*_valid = 0, rsp*_result = 0, rsp*_zero = 0, rsp*_tag = 0, rsp*_err = 0. Combinational outputs follow inputs and state after reset.
- Latency: accept in cycle N -> rspN_valid = 1 in cycle N+1.
- Throughput: one ALU operation per cycle total; each requester gets one operation every cycle alone, or every other cycle under continuous contention.
- Critical path: request mux -> external ALU -> response register within one cycle.
- rst asserted mid-operation: any result being captured that cycle is discarded; all slots empty next cycle; no response issued for requests accepted in the reset cycle.

## Configuration
- ALU_ARB_ILLEGAL_OP_CHK_EN defined: opcodes 0xA-0xF are still accepted, but the ALU is driven as if idle (operands 0, control 0x0), and the response loads result 0, zero 1, err 1.
- Undefined: no decode. Opcode forwarded as-is to the ALU, whose default output is 0, so the response is result 0, zero 1. rsp*_err tied 0.

## Test plan
- Single op: req0 ADD a=0x0000_0005, b=0x0000_0003, tag=3 -> req0_ready same cycle; next cycle rsp0_valid=1, result=0x8, zero=0, tag=3.
- Contention after reset: both valid with continuous requests, rsp always ready -> grants alternate 0,1,0,1. req1 SUB 7-7 gives result 0, zero=1.
- Back-pressure: rsp0_ready=0 with rsp0 full and req0 valid -> req0_ready=0 indefinitely while req1 is still granted every cycle. Raising rsp0_ready -> drain and reload in the same cycle, rsp0_valid stays 1.
- Signed ops: req1 SRA a=0x8000_0000, b=4 -> 0xF800_0000. SLT a=0xFFFF_FFFF, b=1 -> 1. SLTU with the same operands -> 0.
- Illegal op 0xC: with macro -> result 0, zero 1, err 1, ALU sees control 0x0. Without macro -> result 0, err 0.
- Reset mid-stream: assert rst in the cycle of a grant -> next cycle rsp*_valid=0. After release, the first contention goes to requester 0.
